// File: rtl/operand_shifter.sv
// operand_shifter: registered ARM operand-2 shifter with Rs amount fetch; define OPERAND_SHIFTER_RRX_EN to make immediate ROR #0 an RRX
module operand_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       instr,
  input  logic [WIDTH-1:0] rm_value,
  input  logic             carry_in,
  output logic             rs_req,
  output logic [3:0]       rs_addr,
  input  logic [WIDTH-1:0] rs_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int NW = AMT_W > 5 ? AMT_W : 5;
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW:0] WL = (KW+1)'(WIDTH);
`ifdef OPERAND_SHIFTER_RRX_EN
  localparam bit RRX = 1'b1;
`else
  localparam bit RRX = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RDREG, OUT} state_t;
  state_t state;
  logic [1:0] typ_q, typ;
  logic [WIDTH-1:0] v_q, sv, ror;
  logic c_q, sc, sel_reg;
  logic [NW-1:0] n, ne;
  logic [KW-1:0] k;
  logic [WIDTH:0] lsl, lsr, asr, zero, nxt;
  assign in_ready = !reset && (state == IDLE || (state == OUT && out_ready));
  // One shifter serves both paths: live inputs for immediates, captured operands in RDREG.
  // Each shift is done one bit wider so the last bit shifted out lands in the carry position.
  always_comb begin
    sel_reg = state == RDREG;
    typ = sel_reg ? typ_q : instr[2:1];
    sv = sel_reg ? v_q : rm_value;
    sc = sel_reg ? c_q : carry_in;
    n = sel_reg ? NW'(AMT_W'(rs_value)) : NW'(instr[7:3]);
    ne = (!sel_reg && n == '0 && ^typ) ? NW'(WIDTH) : n;
    k = ne[KW-1:0];
    lsl = {1'b0, sv} << ne;
    lsr = {sv, 1'b0} >> ne;
    asr = $signed({sv, 1'b0}) >>> ne;
    ror = (sv >> k) | (sv << (WL - {1'b0, k}));
    zero = (!sel_reg && typ == 2'b11 && RRX) ? {sv[0], sc, sv[WIDTH-1:1]} : {sc, sv};
    nxt = ne == '0 ? zero :
          typ == 2'b00 ? lsl :
          typ == 2'b01 ? {lsr[0], lsr[WIDTH:1]} :
          typ == 2'b10 ? {asr[0], asr[WIDTH:1]} : {ror[WIDTH-1], ror};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
      rs_req <= 1'b0;
      rs_addr <= '0;
      typ_q <= '0;
      v_q <= '0;
      c_q <= 1'b0;
    end else begin
      rs_req <= 1'b0;
      if (state == RDREG) begin
        {carry_out, result} <= nxt;
        out_valid <= 1'b1;
        state <= OUT;
      end else if (in_valid && in_ready) begin
        typ_q <= instr[2:1];
        v_q <= rm_value;
        c_q <= carry_in;
        if (instr[0]) begin
          state <= RDREG;
          rs_req <= 1'b1;
          rs_addr <= instr[7:4];
          out_valid <= 1'b0;
        end else begin
          state <= OUT;
          out_valid <= 1'b1;
          {carry_out, result} <= nxt;
        end
      end else if (state == OUT && out_ready) begin
        state <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_shifter.sv
// tb_operand_shifter: directed vector table plus back-pressure and mid-operation reset sequences
module tb_operand_shifter;
  logic clk, reset, in_valid, in_ready, carry_in, rs_req, out_valid, out_ready, carry_out;
  logic [7:0] instr;
  logic [31:0] rm_value, rs_value, result;
  logic [3:0] rs_addr;
  int n_chk = 0;
  int n_fail = 0;
`ifdef OPERAND_SHIFTER_RRX_EN
  localparam bit RRX = 1'b1;
`else
  localparam bit RRX = 1'b0;
`endif
  typedef struct {
    logic [7:0]  instr;
    logic [31:0] v;
    logic        c;
    logic [31:0] rs;
    logic [31:0] er;
    logic        ec;
  } vec_t;
  vec_t vt[17];

  operand_shifter #(.WIDTH(32), .AMT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rm_value(rm_value), .carry_in(carry_in),
    .rs_req(rs_req), .rs_addr(rs_addr), .rs_value(rs_value),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int cyc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    instr = vt[idx].instr;
    rm_value = vt[idx].v;
    carry_in = vt[idx].c;
    rs_value = vt[idx].rs;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rm_value = 32'hDEAD_BEEF;
    carry_in = ~vt[idx].c;
    cyc = 1;
    @(negedge clk);
    if (vt[idx].instr[0]) begin
      chk({tag, " rs_req"}, 64'(rs_req), 64'd1);
      chk({tag, " rs_addr"}, 64'(rs_addr), 64'(vt[idx].instr[7:4]));
    end
    while (!out_valid && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), vt[idx].instr[0] ? 64'd2 : 64'd1);
    chk({tag, " result"}, 64'(result), 64'(vt[idx].er));
    chk({tag, " carry"}, 64'(carry_out), 64'(vt[idx].ec));
    if (vt[idx].instr[0]) chk({tag, " rs_req one cycle"}, 64'(rs_req), 64'd0);
  endtask

  initial begin
    vt[0]  = '{8'h20, 32'h8000_000F, 1'b0, 32'h0,        32'h0000_00F0, 1'b0};
    vt[1]  = '{8'h33, 32'hFFFF_FFFF, 1'b0, 32'h21,       32'h0,         1'b0};
    vt[2]  = '{8'h04, 32'h8000_0000, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b1};
    vt[3]  = '{8'h06, 32'h0000_0001, 1'b1, 32'h0,        RRX ? 32'h8000_0000 : 32'h1, 1'b1};
    vt[4]  = '{8'h00, 32'h1234_5678, 1'b1, 32'h0,        32'h1234_5678, 1'b1};
    vt[5]  = '{8'h02, 32'h8000_0001, 1'b0, 32'h0,        32'h0,         1'b1};
    vt[6]  = '{8'h0A, 32'h0000_0003, 1'b0, 32'h0,        32'h0000_0001, 1'b1};
    vt[7]  = '{8'h46, 32'h1234_5678, 1'b1, 32'h0,        32'h7812_3456, 1'b0};
    vt[8]  = '{8'hF8, 32'h0000_0003, 1'b0, 32'h0,        32'h8000_0000, 1'b1};
    vt[9]  = '{8'h51, 32'h0000_0001, 1'b0, 32'h20,       32'h0,         1'b1};
    vt[10] = '{8'h51, 32'hFFFF_FFFF, 1'b1, 32'h21,       32'h0,         1'b0};
    vt[11] = '{8'h77, 32'hABCD_0000, 1'b1, 32'h100,      32'hABCD_0000, 1'b1};
    vt[12] = '{8'h25, 32'h7FFF_FFFF, 1'b1, 32'h28,       32'h0,         1'b0};
    vt[13] = '{8'h17, 32'h8000_0001, 1'b0, 32'h20,       32'h8000_0001, 1'b1};
    vt[14] = '{8'h17, 32'h0000_000F, 1'b0, 32'h4,        32'hF000_0000, 1'b1};
    vt[15] = '{8'h33, 32'h8000_0000, 1'b0, 32'h20,       32'h0,         1'b1};
    vt[16] = '{8'h24, 32'h8000_0008, 1'b0, 32'h0,        32'hF800_0000, 1'b1};
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    instr = '0;
    rm_value = '0;
    carry_in = 1'b0;
    rs_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset carry", 64'(carry_out), 64'd0);
    chk("reset rs_req", 64'(rs_req), 64'd0);
    chk("reset rs_addr", 64'(rs_addr), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) run_vec(i);

    // back-pressure: result holds, no accept, then release accepts in the same cycle
    @(negedge clk);
    out_ready = 1'b0;
    instr = 8'h20;
    rm_value = 32'h1;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 instr = 8'h0A;
    rm_value = 32'h6;
    carry_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold valid %0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold result %0d", i), 64'(result), 64'h10);
      chk($sformatf("bp hold in_ready %0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp next valid", 64'(out_valid), 64'd1);
    chk("bp next result", 64'(result), 64'h3);
    chk("bp next carry", 64'(carry_out), 64'd0);

    // reset while in RDREG discards the transaction
    @(negedge clk);
    instr = 8'h33;
    rm_value = 32'h2;
    rs_value = 32'h1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst rdreg rs_req", 64'(rs_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst rs_req", 64'(rs_req), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    reset = 1'b0;
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_shifter.md
# operand_shifter

Registered, parametrised operand-2 shifter for the ARM datapath, sitting between register-file read and the ALU B input. It decodes the 8-bit shift field (instruction bits 11:4), fetches the shift amount from Rs when needed, and produces the shifted value and shifter carry-out. It generalises the existing combinational shift decoder with:

- a configurable datapath width;
- full ARM boundary semantics (amount 0, amount ≥ WIDTH, immediate #0 encodings);
- a carry output;
- a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- AMT_W, 8, width of the register-specified amount taken from Rs bits AMT_W-1:0; must satisfy 2^AMT_W > WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- instr  in  8  shift field:
  - bit0 = 1: register amount; bits 7:4 = Rs.
  - bit0 = 0: immediate amount in bits 7:3.
  - bits 2:1: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- rm_value  in  WIDTH  value to shift, sampled on accept.
- carry_in  in  1  current C flag, sampled on accept.
- rs_req  out  1  register-read strobe for the Rs amount.
- rs_addr  out  4  Rs index; valid while rs_req = 1.
- rs_value  in  WIDTH  Rs contents from the combinational register-file read port.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted operand.
- carry_out  out  1  shifter carry.

## Operation
- A request is accepted when in_valid && in_ready. On accept, instr, rm_value and carry_in are captured.

States:
- IDLE: in_ready = 1.
- RDREG: rs_req = 1, rs_addr = captured instr[7:4], in_ready = 0. rs_value[AMT_W-1:0] is captured at the end of the cycle. Next state is OUT.
- OUT: out_valid = 1. result and carry_out stay stable until out_ready.
  - in_ready = out_ready.
  - out_ready && in_valid: accept the next request; go to OUT (immediate) or RDREG (register).
  - out_ready && !in_valid: go to IDLE.

Transitions on accept from IDLE: to OUT for an immediate amount, to RDREG for a register amount.

Amount semantics, with n = amount, v = rm_value, c = carry_in, W = WIDTH:
- Register n = 0 (any type): result = v, carry = c.
- Immediate LSL #0: result = v, carry = c.
- Immediate LSR #0 and ASR #0: treated as n = W.
- Immediate ROR #0: RRX (see Configuration).
- LSL, 0 < n < W: result = v << n, carry = v[W-n].
- LSL, n = W: result 0, carry = v[0].
- LSL, n > W: result 0, carry 0.
- LSR, 0 < n < W: result = v >> n, carry = v[n-1].
- LSR, n = W: result 0, carry = v[W-1].
- LSR, n > W: result 0, carry 0.
- ASR, 0 < n < W: arithmetic right shift, carry = v[n-1].
- ASR, n ≥ W: result = all bits equal v[W-1], carry = v[W-1].
- ROR, n nonzero: rotate by n mod W.
  - carry = result[W-1].
  - If n mod W = 0: result = v, carry = v[W-1].

Width rules:
- The immediate amount is zero-extended.
- For W < 32, immediate amounts ≥ W follow the n ≥ W rules above.
- The register amount uses only bits AMT_W-1:0 of Rs.

## Timing
- Latency from accept to out_valid:
  - Immediate: 1 cycle.
  - Register: 2 cycles.
- Throughput:
  - Immediate: 1 per cycle when out_ready is held high.
  - Register: 1 per 2 cycles.
- Result and carry are registered outputs; no combinational path from rm_value to result.
- rs_req is high for exactly one cycle per register request.
- Reset values: state IDLE, out_valid 0, result 0, carry_out 0, rs_req 0, rs_addr 0. in_ready is 0 during reset and 1 in the first cycle after.
- Reset mid-operation (RDREG or OUT) discards the transaction; no out_valid is produced for it.
- out_valid && !out_ready: all outputs hold and no request is accepted.

## Configuration
- OPERAND_SHIFTER_RRX_EN defined: immediate ROR #0 is RRX.
  - result = {c, v[W-1:1]}, carry = v[0].
- OPERAND_SHIFTER_RRX_EN undefined: immediate ROR #0 passes through.
  - result = v, carry = c.
- Register ROR with n = 0 is unaffected in both builds.

## Test plan
- Immediate LSL #4 (instr 8'h20), v = 32'h8000_000F, c = 0 → out_valid at +1 cycle, result 32'h0000_00F0, carry 0.
- Register LSR (instr 8'h33, Rs = 3), rs_value = 32'h0000_0021 (n = 33), v = 32'hFFFF_FFFF → rs_req at +1 with rs_addr 3, out_valid at +2, result 0, carry 0.
- Immediate ASR #0 (instr 8'h04), v = 32'h8000_0000 → result 32'hFFFF_FFFF, carry 1.
- Immediate ROR #0 (instr 8'h06), v = 32'h0000_0001, c = 1:
  - With RRX_EN → result 32'h8000_0000, carry 1.
  - Without → result 32'h0000_0001, carry 1.
- Back-pressure: hold out_ready = 0 for 3 cycles with in_valid high → result stable, in_ready 0. Release → next request accepted in the same cycle, its result valid the next cycle.
- Assert reset during RDREG → the following cycle has out_valid 0, rs_req 0, result 0. A new immediate request then completes normally.
